// File: rtl/line_fetch_arb.sv
// Per-scanline round-robin scheduler that shares one sprite/tile ROM read port
// among N_REQ fetch engines and routes each ROM return back to the requester that issued it.
module line_fetch_arb #(
  parameter int N_REQ   = 4,
  parameter int AW      = 12,
  parameter int DW      = 16,
  parameter int ROM_LAT = 1,
  parameter int WINDOW  = 256
) (
  input  logic               i_clk_pix,
  input  logic               i_rst,
  input  logic               i_line,
  input  logic               i_frame,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*AW-1:0] i_addr,
  output logic [N_REQ-1:0]   o_gnt,
  output logic               o_rom_en,
  output logic [AW-1:0]      o_rom_addr,
  input  logic [DW-1:0]      i_rom_data,
  output logic [N_REQ-1:0]   o_rvalid,
  output logic [DW-1:0]      o_rdata,
  output logic               o_busy,
  output logic               o_overrun,
  output logic [7:0]         o_overrun_cnt
);

  localparam int RRW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW  = $clog2(WINDOW + 1);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    win_cnt_q, win_cnt_d;
  logic [RRW-1:0]   rr_q, rr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [AW-1:0]    rom_addr_q, rom_addr_d;
  logic [N_REQ-1:0] tag_q [ROM_LAT];
  logic [N_REQ-1:0] tag_d [ROM_LAT];
  logic [N_REQ-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       ovr_cnt_q, ovr_cnt_d;

  logic [AW-1:0]    addr_arr [N_REQ];
  logic [N_REQ-1:0] elig;
  logic [RRW-1:0]   rr_eff, pick;
  logic             found, expiring;

  // Window FSM: ACTIVE holds for WINDOW cycles after the most recent i_line.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    expiring  = 1'b0;
    if (i_line) begin
      state_d   = ACTIVE;
      win_cnt_d = CW'(WINDOW);
    end else if (state_q == ACTIVE) begin
      win_cnt_d = win_cnt_q - CW'(1);
      if (win_cnt_q == CW'(1)) begin
        state_d  = IDLE;
        expiring = 1'b1;
      end
    end
  end

  // A requester granted this cycle sits out one decision so it can drop or retarget i_req.
  always_comb begin
    int idx;
    idx    = 0;
    elig   = i_req & ~gnt_q;
    rr_eff = i_frame ? '0 : rr_q;
    found  = 1'b0;
    pick   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      addr_arr[k] = i_addr[k*AW +: AW];
    end
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_eff) + i) % N_REQ;
      if (!found && elig[RRW'(idx)]) begin
        found = 1'b1;
        pick  = RRW'(idx);
      end
    end
  end

  // Decide only when the registered grant will land in an ACTIVE cycle.
  always_comb begin
    gnt_d      = '0;
    rom_addr_d = rom_addr_q;
    rr_d       = rr_eff;
    if (found && state_d == ACTIVE) begin
      gnt_d[pick] = 1'b1;
      rom_addr_d  = addr_arr[pick];
      rr_d        = (int'(pick) == N_REQ - 1) ? '0 : pick + 1'b1;
    end
  end

  always_comb begin
    tag_d[0] = gnt_q;
    for (int i = 1; i < ROM_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    rvalid_d = tag_q[ROM_LAT-1];
    rdata_d  = (|tag_q[ROM_LAT-1]) ? i_rom_data : rdata_q;

    overrun_d = expiring && (|elig);
    ovr_cnt_d = ovr_cnt_q;
    if (overrun_d && ovr_cnt_q != 8'hFF) begin
      ovr_cnt_d = ovr_cnt_q + 8'd1;
    end
    if (i_frame) begin
      ovr_cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk_pix) begin
    if (i_rst) begin
      state_q    <= IDLE;
      win_cnt_q  <= '0;
      rr_q       <= '0;
      gnt_q      <= '0;
      rom_addr_q <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
      overrun_q  <= 1'b0;
      ovr_cnt_q  <= '0;
      // NOTE: the tag pipeline is reset on purpose so reads in flight at reset never return.
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      rom_addr_q <= rom_addr_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      overrun_q  <= overrun_d;
      ovr_cnt_q  <= ovr_cnt_d;
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign o_gnt         = gnt_q;
  assign o_rom_en      = |gnt_q;
  assign o_rom_addr    = rom_addr_q;
  assign o_rvalid      = rvalid_q;
  assign o_rdata       = rdata_q;
  assign o_busy        = (state_q == ACTIVE);
  assign o_overrun     = overrun_q;
  assign o_overrun_cnt = ovr_cnt_q;

endmodule
